axi4_user_arbiter: RTL and testbench

- Round-robin scheduler that shares one axi4_top user interface (wr_tx/rd_tx command port, wr_done/rd_done completion, rd_data stream) between NUM_REQ independent requesters.
- Accepts one burst command (read or write) at a time and drives it into axi4_top as a single-cycle wr_tx/rd_tx pulse.
- Holds ownership until the matching completion, then routes completion and read data back to the owning requester.
- Sits directly above axi4_top, between it and the client blocks.

---
 rtl/axi4_arb_pkg.sv | 34 +++
 rtl/axi4_user_arbiter_rr.sv | 32 +++
 rtl/axi4_user_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_axi4_user_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_arb_pkg.sv
// axi4_arb_pkg: shared types and constants for the axi4_user_arbiter slice.
// Holds the FSM state encoding, the AXI field constants and the round-robin helper.
package axi4_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_4B = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [DATA_W-1:0] wdata;
  } arb_cmd_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axi4_user_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, search starts at ptr_i.
// Ports: req_i requests, ptr_i start index, grant_o one-hot, idx_o index, valid_o any.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  int c;

  // Walk from the farthest slot back to ptr so the closest hit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    c       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = (int'(ptr_i) + k) % NUM_REQ;
      if (req_i[c]) begin
        idx_o   = IDX_W'(c);
        valid_o = 1'b1;
      end
    end
    if (valid_o) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/axi4_user_arbiter.sv
// axi4_user_arbiter: round-robin share of one axi4_top user port among NUM_REQ clients.
// Ports: req_* per requester, resp_* to owner, wr_*/rd_* to axi4_top; AXI_ARB_TIMEOUT_EN adds timeout.
module axi4_user_arbiter
  import axi4_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ*3-1:0]      req_size,
  input  logic [NUM_REQ*2-1:0]      req_burst,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        resp_done,
  output logic [NUM_REQ-1:0]        resp_rvalid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic [NUM_REQ-1:0]        resp_err,
  output logic                      wr_tx,
  output logic                      rd_tx,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [ADDR_W-1:0]         rd_addr,
  output logic [LEN_W-1:0]          wr_len,
  output logic [LEN_W-1:0]          rd_len,
  output logic [2:0]                wr_size,
  output logic [2:0]                rd_size,
  output logic [1:0]                wr_burst,
  output logic [1:0]                rd_burst,
  output logic [DATA_W-1:0]         wr_data,
  input  logic                      wr_done,
  input  logic                      rd_done,
  input  logic                      rd_data_valid,
  input  logic [DATA_W-1:0]         rd_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  arb_cmd_t           cmd_q, cmd_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  arb_cmd_t           sel_cmd;
  logic [NUM_REQ-1:0] owner_oh;
  logic [IDX_W-1:0]   ptr_nxt;
  logic               wr_sel;
  logic               rd_sel;
  logic               rd_fwd;
  logic               timeout;
  logic               to_fire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_any)
  );

  always_comb begin
    sel_cmd.write = req_write[gnt_idx];
    sel_cmd.addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
    sel_cmd.len   = req_len[gnt_idx*LEN_W +: LEN_W];
    sel_cmd.size  = req_size[gnt_idx*3 +: 3];
    sel_cmd.burst = req_burst[gnt_idx*2 +: 2];
    sel_cmd.wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];
  end

  assign owner_oh = NUM_REQ'(1) << owner_q;
  assign ptr_nxt  = IDX_W'(rr_next(int'(owner_q), NUM_REQ));

  // Ready is masked while reset is held so nothing looks accepted.
  assign req_ready = (state_q == IDLE && reset) ? gnt : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cmd_d   = cmd_q;
    done_d  = '0;
    to_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          owner_d = gnt_idx;
          cmd_d   = sel_cmd;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (cmd_q.write ? wr_done : rd_done) begin
          done_d  = owner_oh;
          ptr_d   = ptr_nxt;
          state_d = IDLE;
        end else if (timeout) begin
          to_fire = 1'b1;
          ptr_d   = ptr_nxt;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_sel = (state_q != IDLE) && cmd_q.write;
  assign rd_sel = (state_q != IDLE) && !cmd_q.write;
  assign rd_fwd = rd_sel && rd_data_valid;

  assign rvalid_d = rd_fwd ? owner_oh : '0;
  assign rdata_d  = rd_fwd ? rd_data : rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      cmd_q    <= '0;
      done_q   <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cmd_q    <= cmd_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef AXI_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0] err_q, err_d;

  // Counter is zero on the first WAIT cycle and counts every WAIT cycle.
  assign cnt_d   = (state_q == WAIT) ? cnt_q + 16'd1 : '0;
  assign timeout = (cnt_q == TO_LAST);
  assign err_d   = to_fire ? owner_oh : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign resp_err = err_q;
`else
  logic unused_cfg;

  assign timeout    = 1'b0;
  assign resp_err   = '0;
  assign unused_cfg = ^{32'(TIMEOUT_CYCLES), to_fire};
`endif

  assign resp_done   = done_q;
  assign resp_rvalid = rvalid_q;
  assign resp_rdata  = rdata_q;

  assign wr_tx    = (state_q == ISSUE) && cmd_q.write;
  assign rd_tx    = (state_q == ISSUE) && !cmd_q.write;
  assign wr_addr  = wr_sel ? cmd_q.addr  : '0;
  assign wr_len   = wr_sel ? cmd_q.len   : '0;
  assign wr_size  = wr_sel ? cmd_q.size  : '0;
  assign wr_burst = wr_sel ? cmd_q.burst : '0;
  assign wr_data  = wr_sel ? cmd_q.wdata : '0;
  assign rd_addr  = rd_sel ? cmd_q.addr  : '0;
  assign rd_len   = rd_sel ? cmd_q.len   : '0;
  assign rd_size  = rd_sel ? cmd_q.size  : '0;
  assign rd_burst = rd_sel ? cmd_q.burst : '0;

endmodule

// File: tb/tb_axi4_user_arbiter.sv
// tb_axi4_user_arbiter: randomized self-checking bench for axi4_user_arbiter.
// Expected grants, pulses and data come from a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_axi4_user_arbiter;
  import axi4_arb_pkg::*;

  localparam int N  = 3;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  logic [N-1:0]    req_valid, req_ready, req_write;
  logic [N*32-1:0] req_addr, req_wdata;
  logic [N*8-1:0]  req_len;
  logic [N*3-1:0]  req_size;
  logic [N*2-1:0]  req_burst;
  logic [N-1:0]    resp_done, resp_rvalid, resp_err;
  logic [31:0]     resp_rdata;
  logic            wr_tx, rd_tx;
  logic [31:0]     wr_addr, rd_addr, wr_data;
  logic [7:0]      wr_len, rd_len;
  logic [2:0]      wr_size, rd_size;
  logic [1:0]      wr_burst, rd_burst;
  logic            wr_done, rd_done, rd_data_valid;
  logic [31:0]     rd_data;

  int errors = 0;
  int checks = 0;
  int ptr    = 0;

  axi4_user_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_len       (req_len),
    .req_size      (req_size),
    .req_burst     (req_burst),
    .req_wdata     (req_wdata),
    .resp_done     (resp_done),
    .resp_rvalid   (resp_rvalid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .wr_tx         (wr_tx),
    .rd_tx         (rd_tx),
    .wr_addr       (wr_addr),
    .rd_addr       (rd_addr),
    .wr_len        (wr_len),
    .rd_len        (rd_len),
    .wr_size       (wr_size),
    .rd_size       (rd_size),
    .wr_burst      (wr_burst),
    .rd_burst      (rd_burst),
    .wr_data       (wr_data),
    .wr_done       (wr_done),
    .rd_done       (rd_done),
    .rd_data_valid (rd_data_valid),
    .rd_data       (rd_data)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++)
      if (m[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  task automatic set_req(input int i, input logic w,
                         input logic [31:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b,
                         input logic [31:0] wd);
    req_write[i]          = w;
    req_addr[32*i +: 32]  = a;
    req_len[8*i +: 8]     = l;
    req_size[3*i +: 3]    = s;
    req_burst[2*i +: 2]   = b;
    req_wdata[32*i +: 32] = wd;
  endtask

  // One command from grant to completion; read owners get len+1 beats
  // starting in ISSUE, the done lands with or after the last beat.
  task automatic run_txn(input logic [N-1:0] mask, input int done_at,
                         input logic [31:0] dbase, input bit spur);
    int          g;
    int          nb;
    logic        w;
    logic [31:0] a, wd, pdata;
    logic [7:0]  l;
    logic [2:0]  s;
    logic [1:0]  b;
    logic        pbeat;
    logic [N-1:0] oh;
    logic [76:0] exp_wr;
    logic [44:0] exp_rd;
    g  = pick(mask);
    oh = N'(1) << g;
    req_valid = mask;
    #1;
    checks++;
    if (req_ready !== oh) begin
      errors++;
      $display("FAIL grant: req_ready=%b expected %b", req_ready, oh);
    end
    w  = req_write[g];
    a  = req_addr[32*g +: 32];
    l  = req_len[8*g +: 8];
    s  = req_size[3*g +: 3];
    b  = req_burst[2*g +: 2];
    wd = req_wdata[32*g +: 32];
    nb = w ? 0 : int'(l) + 1;
    if (done_at < 1) done_at = 1;
    if (!w && done_at < nb - 1) done_at = nb - 1;
    exp_wr = w ? {a, l, s, b, wd} : 77'h0;
    exp_rd = w ? 45'h0 : {a, l, s, b};
    @(negedge clk);
    req_valid[g] = 1'b0;
    pbeat = 1'b0;
    pdata = '0;
    for (int k = 0; k <= done_at; k++) begin
      checks++;
      if (wr_tx !== (k == 0 && w) || rd_tx !== (k == 0 && !w)) begin
        errors++;
        $display("FAIL tx_pulse k=%0d: wr_tx=%b rd_tx=%b expected %b %b",
                 k, wr_tx, rd_tx, k == 0 && w, k == 0 && !w);
      end
      checks++;
      if ({wr_addr, wr_len, wr_size, wr_burst, wr_data} !== exp_wr) begin
        errors++;
        $display("FAIL wr_fields k=%0d: got %h expected %h", k,
                 {wr_addr, wr_len, wr_size, wr_burst, wr_data}, exp_wr);
      end
      checks++;
      if ({rd_addr, rd_len, rd_size, rd_burst} !== exp_rd) begin
        errors++;
        $display("FAIL rd_fields k=%0d: got %h expected %h", k,
                 {rd_addr, rd_len, rd_size, rd_burst}, exp_rd);
      end
      checks++;
      if (resp_rvalid !== (pbeat ? oh : '0) ||
          (pbeat && resp_rdata !== pdata)) begin
        errors++;
        $display("FAIL rvalid k=%0d: rvalid=%b rdata=%h expected %b %h",
                 k, resp_rvalid, resp_rdata, pbeat ? oh : '0, pdata);
      end
      checks++;
      if (resp_done !== '0 || resp_err !== '0) begin
        errors++;
        $display("FAIL early_resp k=%0d: done=%b err=%b expected 0 0",
                 k, resp_done, resp_err);
      end
      pbeat         = !w && k < nb;
      pdata         = dbase + 32'(k);
      rd_data_valid = (w && spur) ? 1'b1 : pbeat;
      rd_data       = pbeat ? pdata : $urandom;
      wr_done       = (k == done_at && w) || (spur && !w && k > 0);
      rd_done       = (k == done_at && !w) || (spur && w && k > 0);
      #1;
      checks++;
      if (req_ready !== '0) begin
        errors++;
        $display("FAIL busy_ready k=%0d: req_ready=%b expected 0", k, req_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (resp_done !== oh || resp_err !== '0) begin
      errors++;
      $display("FAIL done: resp_done=%b err=%b expected %b 0",
               resp_done, resp_err, oh);
    end
    checks++;
    if (resp_rvalid !== (pbeat ? oh : '0) ||
        (pbeat && resp_rdata !== pdata) || wr_tx !== 1'b0 || rd_tx !== 1'b0) begin
      errors++;
      $display("FAIL last_beat: rvalid=%b rdata=%h expected %b %h",
               resp_rvalid, resp_rdata, pbeat ? oh : '0, pdata);
    end
    wr_done       = 1'b0;
    rd_done       = 1'b0;
    rd_data_valid = 1'b0;
    ptr           = (g + 1) % N;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = '1;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, resp_done, resp_rvalid, resp_rdata, resp_err, wr_tx, rd_tx,
         wr_addr, wr_len, wr_size, wr_burst, wr_data,
         rd_addr, rd_len, rd_size, rd_burst} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req_ready=%b wr_tx=%b rd_tx=%b expected all 0",
               req_ready, wr_tx, rd_tx);
    end
    req_valid = '0;
    reset     = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_done, resp_rvalid, wr_tx, rd_tx} !== '0) begin
      errors++;
      $display("FAIL post_reset: ready=%b done=%b rvalid=%b expected 0",
               req_ready, resp_done, resp_rvalid);
    end
    ptr = 0;
  endtask

  task automatic test_single_write();
    set_req(0, 1'b1, 32'h1, 8'd1, SIZE_4B, BURST_FIXED, 32'h100);
    run_txn(3'b001, 2, 32'h0, 1'b0);
  endtask

  task automatic test_contention();
    set_req(0, 1'b1, 32'h10, 8'd0, SIZE_4B, BURST_INCR, 32'hA0);
    set_req(1, 1'b0, 32'h20, 8'd1, SIZE_4B, BURST_INCR, 32'h0);
    set_req(2, 1'b1, 32'h30, 8'd2, SIZE_4B, BURST_WRAP, 32'hC0);
    run_txn(3'b011, 1, 32'h200, 1'b0);
    run_txn(3'b010, 1, 32'h210, 1'b0);
    run_txn(3'b011, 1, 32'h220, 1'b0);
    run_txn(3'b110, 3, 32'h230, 1'b0);
    run_txn(3'b100, 1, 32'h240, 1'b0);
    req_valid = '0;
  endtask

  task automatic test_read_routing();
    set_req(1, 1'b0, 32'd48, 8'd7, SIZE_4B, BURST_WRAP, 32'h0);
    run_txn(3'b010, 7, 32'h300, 1'b0);
  endtask

  task automatic test_spurious();
    wr_done       = 1'b1;
    rd_done       = 1'b1;
    rd_data_valid = 1'b1;
    rd_data       = 32'hBAD0BAD0;
    @(negedge clk);
    wr_done       = 1'b0;
    rd_done       = 1'b0;
    rd_data_valid = 1'b0;
    checks++;
    if ({resp_done, resp_rvalid, req_ready, wr_tx, rd_tx} !== '0) begin
      errors++;
      $display("FAIL idle_spurious: done=%b rvalid=%b tx=%b%b expected 0",
               resp_done, resp_rvalid, wr_tx, rd_tx);
    end
    set_req(2, 1'b1, 32'h400, 8'd3, SIZE_4B, BURST_INCR, 32'h44);
    run_txn(3'b100, 4, 32'h0, 1'b1);
    set_req(0, 1'b0, 32'h500, 8'd2, SIZE_4B, BURST_INCR, 32'h0);
    run_txn(3'b001, 5, 32'h500, 1'b1);
  endtask

  task automatic test_reset_mid();
    set_req(2, 1'b0, 32'h40, 8'd3, SIZE_4B, BURST_INCR, 32'h0);
    req_valid = 3'b100;
    @(negedge clk);
    req_valid = 3'b001;
    checks++;
    if (rd_tx !== 1'b1) begin
      errors++;
      $display("FAIL mid_issue: rd_tx=%b expected 1", rd_tx);
    end
    rd_data_valid = 1'b1;
    rd_data       = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (resp_rvalid !== 3'b100 || resp_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL mid_beat: rvalid=%b rdata=%h expected 100 deadbeef",
               resp_rvalid, resp_rdata);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_done, resp_rvalid, resp_rdata, resp_err, wr_tx, rd_tx,
         wr_addr, wr_len, wr_size, wr_burst, wr_data,
         rd_addr, rd_len, rd_size, rd_burst} !== '0) begin
      errors++;
      $display("FAIL mid_reset: rvalid=%b rdata=%h rd_addr=%h expected all 0",
               resp_rvalid, resp_rdata, rd_addr);
    end
    @(negedge clk);
    rd_data_valid = 1'b0;
    req_valid     = '0;
    rd_done       = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    reset   = 1'b1;
    ptr     = 0;
    @(negedge clk);
    checks++;
    if (resp_done !== '0 || resp_rvalid !== '0) begin
      errors++;
      $display("FAIL after_reset: done=%b rvalid=%b expected 0",
               resp_done, resp_rvalid);
    end
    set_req(0, 1'b1, 32'h600, 8'd0, SIZE_4B, BURST_FIXED, 32'h66);
    set_req(1, 1'b0, 32'h700, 8'd1, SIZE_4B, BURST_INCR, 32'h0);
    run_txn(3'b011, 2, 32'h0, 1'b0);
    req_valid = '0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom), $urandom, 8'($urandom_range(0, 7)),
                3'($urandom), 2'($urandom_range(0, 2)), $urandom);
      run_txn(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(1, 6),
              $urandom, 1'($urandom));
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
`ifdef AXI_ARB_TIMEOUT_EN
    logic [N-1:0] oh;
    int           g;
    set_req(1, 1'b1, 32'h80, 8'd0, SIZE_4B, BURST_INCR, 32'h55);
    req_valid = 3'b010;
    g  = pick(3'b010);
    oh = N'(1) << g;
    #1;
    checks++;
    if (req_ready !== oh) begin
      errors++;
      $display("FAIL to_grant: req_ready=%b expected %b", req_ready, oh);
    end
    @(negedge clk);
    req_valid = '0;
    for (int k = 0; k < 17; k++) begin
      checks++;
      if (resp_err !== '0 || resp_done !== '0) begin
        errors++;
        $display("FAIL to_early k=%0d: err=%b done=%b expected 0 0",
                 k, resp_err, resp_done);
      end
      @(negedge clk);
    end
    checks++;
    if (resp_err !== oh || resp_done !== '0) begin
      errors++;
      $display("FAIL to_err: err=%b done=%b expected %b 0", resp_err, resp_done, oh);
    end
    ptr = (g + 1) % N;
    @(negedge clk);
    checks++;
    if (resp_err !== '0) begin
      errors++;
      $display("FAIL to_pulse: err=%b expected 0", resp_err);
    end
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, 32'h900 + 32'(i), 8'd0, SIZE_4B, BURST_INCR, 32'(i));
    run_txn(3'b111, 1, 32'h0, 1'b0);
    req_valid = '0;
`else
    set_req(1, 1'b1, 32'h80, 8'd0, SIZE_4B, BURST_INCR, 32'h55);
    run_txn(3'b010, 40, 32'h0, 1'b0);
    req_valid = '0;
`endif
  endtask

  initial begin
    req_valid     = '0;
    req_write     = '0;
    req_addr      = '0;
    req_len       = '0;
    req_size      = '0;
    req_burst     = '0;
    req_wdata     = '0;
    wr_done       = 1'b0;
    rd_done       = 1'b0;
    rd_data_valid = 1'b0;
    rd_data       = '0;
    test_reset();
    test_single_write();
    test_contention();
    test_read_routing();
    test_spurious();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
